// File: rtl/ring_fifo_pkg.sv
// rtl/ring_fifo_pkg.sv - shared sizing and pointer-wrap helpers for ring_fifo_cnt
package ring_fifo_pkg;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic int unsigned ptr_wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/ring_fifo_ptr.sv
// rtl/ring_fifo_ptr.sv - wrapping pointer register with synchronous clear
module ring_fifo_ptr
  import ring_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = PW'(ptr_wrap_inc(32'(ptr_q), DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ring_fifo_cnt.sv
// rtl/ring_fifo_cnt.sv - show-ahead ring FIFO with occupancy count and level flags
// Optional sticky overflow/underflow flags under RING_FIFO_ERR_FLAGS_EN.
module ring_fifo_cnt
  import ring_fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          write,
  input  logic [DATA_WIDTH-1:0]         datain,
  input  logic                          read,
  output logic [DATA_WIDTH-1:0]         dataout,
  output logic                          val,
  output logic                          full,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [count_width(DEPTH)-1:0] count
`ifdef RING_FIFO_ERR_FLAGS_EN
  ,
  output logic                          overflow,
  output logic                          underflow
`endif
);

  localparam int CW = count_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  wr_acc, rd_acc;

  // Flags come only from the registered count, so no request reaches an output.
  assign val          = (count_q != '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign dataout      = mem_q[rd_ptr];

  assign wr_acc = write & ~full & ~flush;
  assign rd_acc = read & val & ~flush;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (wr_acc && !rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      mem_q[wr_ptr] <= datain;
    end
  end

  ring_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (wr_acc),
    .ptr   (wr_ptr)
  );

  ring_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (rd_acc),
    .ptr   (rd_ptr)
  );

`ifdef RING_FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky until reset; flush deliberately leaves them set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (write && full) overflow_q <= 1'b1;
      if (read && !val) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_ring_fifo_cnt.sv
// tb/tb_ring_fifo_cnt.sv - self-checking bench for ring_fifo_cnt at depths 4, 5 and 16
module tb_ring_fifo_cnt;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic [7:0] datain = 8'h00;

  logic [7:0] dout4, dout5, dout16;
  logic       val4, val5, val16, full4, full5, full16;
  logic       af4, af5, af16, ae4, ae5, ae16;
  logic [2:0] cnt4, cnt5;
  logic [4:0] cnt16;
`ifdef RING_FIFO_ERR_FLAGS_EN
  logic       ov4, un4, ov5, un5, ov16, un16;
  logic       ov_m, un_m;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] q4[$];
  logic [7:0] q5[$];
  logic [7:0] q16[$];

  always #5 clk = ~clk;

  ring_fifo_cnt #(.DEPTH(4), .DATA_WIDTH(8), .AF_LEVEL(2), .AE_LEVEL(1)) u_d4 (
    .clk(clk), .reset(reset), .flush(flush), .write(write), .datain(datain), .read(read),
    .dataout(dout4), .val(val4), .full(full4), .almost_full(af4), .almost_empty(ae4), .count(cnt4)
`ifdef RING_FIFO_ERR_FLAGS_EN
    , .overflow(ov4), .underflow(un4)
`endif
  );

  ring_fifo_cnt #(.DEPTH(5), .DATA_WIDTH(8), .AF_LEVEL(3), .AE_LEVEL(1)) u_d5 (
    .clk(clk), .reset(reset), .flush(flush), .write(write), .datain(datain), .read(read),
    .dataout(dout5), .val(val5), .full(full5), .almost_full(af5), .almost_empty(ae5), .count(cnt5)
`ifdef RING_FIFO_ERR_FLAGS_EN
    , .overflow(ov5), .underflow(un5)
`endif
  );

  ring_fifo_cnt #(.DEPTH(16), .DATA_WIDTH(8), .AF_LEVEL(14), .AE_LEVEL(1)) u_d16 (
    .clk(clk), .reset(reset), .flush(flush), .write(write), .datain(datain), .read(read),
    .dataout(dout16), .val(val16), .full(full16), .almost_full(af16), .almost_empty(ae16), .count(cnt16)
`ifdef RING_FIFO_ERR_FLAGS_EN
    , .overflow(ov16), .underflow(un16)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain queues, updated from the inputs seen at the clock edge.
  task automatic model_update();
    logic wa4, ra4, wa5, ra5, wa16, ra16;
    if (reset) begin
      q4.delete(); q5.delete(); q16.delete();
`ifdef RING_FIFO_ERR_FLAGS_EN
      ov_m = 1'b0; un_m = 1'b0;
`endif
    end else begin
`ifdef RING_FIFO_ERR_FLAGS_EN
      if (write && q4.size() == 4) ov_m = 1'b1;
      if (read && q4.size() == 0) un_m = 1'b1;
`endif
      if (flush) begin
        q4.delete(); q5.delete(); q16.delete();
      end else begin
        wa4  = write && q4.size() != 4;   ra4  = read && q4.size() != 0;
        wa5  = write && q5.size() != 5;   ra5  = read && q5.size() != 0;
        wa16 = write && q16.size() != 16; ra16 = read && q16.size() != 0;
        if (ra4)  void'(q4.pop_front());
        if (ra5)  void'(q5.pop_front());
        if (ra16) void'(q16.pop_front());
        if (wa4)  q4.push_back(datain);
        if (wa5)  q5.push_back(datain);
        if (wa16) q16.push_back(datain);
      end
    end
  endtask

  task automatic check_all();
    chk("d4_cnt", 32'(cnt4), q4.size());
    chk("d4_val", 32'(val4), 32'(q4.size() != 0));
    chk("d4_full", 32'(full4), 32'(q4.size() == 4));
    chk("d4_af", 32'(af4), 32'(q4.size() >= 2));
    chk("d4_ae", 32'(ae4), 32'(q4.size() <= 1));
    if (q4.size() != 0) chk("d4_dout", 32'(dout4), 32'(q4[0]));
    chk("d5_cnt", 32'(cnt5), q5.size());
    chk("d5_val", 32'(val5), 32'(q5.size() != 0));
    chk("d5_full", 32'(full5), 32'(q5.size() == 5));
    chk("d5_af", 32'(af5), 32'(q5.size() >= 3));
    chk("d5_ae", 32'(ae5), 32'(q5.size() <= 1));
    if (q5.size() != 0) chk("d5_dout", 32'(dout5), 32'(q5[0]));
    chk("d16_cnt", 32'(cnt16), q16.size());
    chk("d16_val", 32'(val16), 32'(q16.size() != 0));
    chk("d16_full", 32'(full16), 32'(q16.size() == 16));
    chk("d16_af", 32'(af16), 32'(q16.size() >= 14));
    chk("d16_ae", 32'(ae16), 32'(q16.size() <= 1));
    if (q16.size() != 0) chk("d16_dout", 32'(dout16), 32'(q16[0]));
`ifdef RING_FIFO_ERR_FLAGS_EN
    chk("d4_ovf", 32'(ov4), 32'(ov_m));
    chk("d4_unf", 32'(un4), 32'(un_m));
`endif
  endtask

  task automatic step(input logic w, input logic r, input logic f, input logic rs, input logic [7:0] d);
    write = w; read = r; flush = f; reset = rs; datain = d;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    int         cnt;
    logic       v;
    logic       fl;
    logic [7:0] dout;
  } vec_t;

  vec_t tv[9];

  initial begin
    tv[0] = '{1'b1, 1'b0, 8'h11, 1, 1'b1, 1'b0, 8'h11};
    tv[1] = '{1'b1, 1'b0, 8'h22, 2, 1'b1, 1'b0, 8'h11};
    tv[2] = '{1'b1, 1'b0, 8'h33, 3, 1'b1, 1'b0, 8'h11};
    tv[3] = '{1'b1, 1'b0, 8'h44, 4, 1'b1, 1'b1, 8'h11};
    tv[4] = '{1'b1, 1'b0, 8'h55, 4, 1'b1, 1'b1, 8'h11};
    tv[5] = '{1'b0, 1'b1, 8'h00, 3, 1'b1, 1'b0, 8'h22};
    tv[6] = '{1'b0, 1'b1, 8'h00, 2, 1'b1, 1'b0, 8'h33};
    tv[7] = '{1'b0, 1'b1, 8'h00, 1, 1'b1, 1'b0, 8'h44};
    tv[8] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 8'h00};

    @(negedge clk);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'hAA);
    chk("rst_cnt", 32'(cnt4), 0);
    chk("rst_val", 32'(val4), 0);
    chk("rst_full", 32'(full4), 0);
    chk("rst_af", 32'(af4), 0);
    chk("rst_ae", 32'(ae4), 1);

    // Fill, overfill, drain on the 4-deep instance.
    for (int i = 0; i < 9; i++) begin
      step(tv[i].w, tv[i].r, 1'b0, 1'b0, tv[i].d);
      chk("t1_cnt", 32'(cnt4), tv[i].cnt);
      chk("t1_val", 32'(val4), 32'(tv[i].v));
      chk("t1_full", 32'(full4), 32'(tv[i].fl));
      if (tv[i].v) chk("t1_dout", 32'(dout4), 32'(tv[i].dout));
    end

    // Full with simultaneous read and write: only the read lands.
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h80 + i));
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'hEE);
    chk("t3_full_rw_cnt4", 32'(cnt4), 3);
    chk("t3_full_rw_cnt16", 32'(cnt16), 15);
    chk("t3_full_rw_dout4", 32'(dout4), 32'h81);

    // Half-full with both requested: count holds, order preserved.
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hA0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hA1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'hB0 + i));
    chk("t3_half_cnt4", 32'(cnt4), 2);
    chk("t3_half_dout4", 32'(dout4), 32'hB4);

    // Almost flags on the 16-deep instance, up then down.
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
      if (i == 1)  chk("t4_ae_at1", 32'(ae16), 1);
      if (i == 2)  chk("t4_ae_at2", 32'(ae16), 0);
      if (i == 13) chk("t4_af_at13", 32'(af16), 0);
      if (i == 14) chk("t4_af_at14", 32'(af16), 1);
      if (i == 16) chk("t4_full16", 32'(full16), 1);
    end
    for (int i = 15; i >= 0; i--) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      if (i == 15) chk("t4_full16_drop", 32'(full16), 0);
      if (i == 13) chk("t4_af_dn13", 32'(af16), 0);
      if (i == 1)  chk("t4_ae_dn1", 32'(ae16), 1);
      if (i == 0)  chk("t4_val_dn0", 32'(val16), 0);
    end

    // Flush beats a same-cycle write.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h03);
    chk("t5_pre_cnt4", 32'(cnt4), 3);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h04);
    chk("t5_flush_cnt4", 32'(cnt4), 0);
    chk("t5_flush_val4", 32'(val4), 0);

    // Random traffic with alternating write-heavy / read-heavy phases for wrap coverage.
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = ((i / 40) % 2) ? 80 : 30;
      step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (110 - wp),
           $urandom_range(0, 99) < 2, 1'b0, 8'($urandom));
    end

    // Reset mid-stream discards contents.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h5B);
    chk("rst_mid_cnt5", 32'(cnt5), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h5C);
    chk("rst_mid_dout5", 32'(dout5), 32'h5C);

`ifdef RING_FIFO_ERR_FLAGS_EN
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
    chk("t6_ovf_clear", 32'(ov4), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
    chk("t6_ovf_set", 32'(ov4), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("t6_ovf_flush", 32'(ov4), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("t6_ovf_reset", 32'(ov4), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("t6_unf_set", 32'(un4), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
